// File: rtl/decode_stage_if.sv
// Handshake bundle between the IF/ID register, hazard controller, writeback
// and the decode stage; the decode stage takes the slave side.
interface decode_stage_if;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic        stall;
  logic        flush;
  logic        v1_mux;
  logic        v2_mux;
  logic [31:0] v1_fw;
  logic [31:0] v2_fw;
  logic        W_en;
  logic [4:0]  W_rd;
  logic [31:0] W_data;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        E_valid;
  logic [31:0] E_pc;
  logic [5:0]  E_op;
  logic [5:0]  E_funct;
  logic [31:0] E_v1;
  logic [31:0] E_v2;
  logic [31:0] E_imm;
  logic [4:0]  E_rd;
  logic        E_is_load;
  logic [31:0] bubble_count;

  modport master (
    output D_valid, D_instr, D_pc, stall, flush, v1_mux, v2_mux, v1_fw, v2_fw,
           W_en, W_rd, W_data,
    input  rs, rt, E_valid, E_pc, E_op, E_funct, E_v1, E_v2, E_imm, E_rd,
           E_is_load, bubble_count
  );

  modport slave (
    input  D_valid, D_instr, D_pc, stall, flush, v1_mux, v2_mux, v1_fw, v2_fw,
           W_en, W_rd, W_data,
    output rs, rt, E_valid, E_pc, E_op, E_funct, E_v1, E_v2, E_imm, E_rd,
           E_is_load, bubble_count
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file, field decode, operand
// resolution (forward > writeback bypass > array) and the ID/EX register.
module decode_stage #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave d
);

  logic [5:0]  op;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = d.D_instr[31:26];
  assign rs_f  = d.D_instr[25:21];
  assign rt_f  = d.D_instr[20:16];
  assign rd_f  = d.D_instr[15:11];
  assign funct = d.D_instr[5:0];
  assign imm16 = d.D_instr[15:0];

  assign d.rs = d.D_valid ? rs_f : 5'd0;
  assign d.rt = d.D_valid ? rt_f : 5'd0;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (d.W_en && (d.W_rd != 5'd0)) begin
      regs_d[d.W_rd] = d.W_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [4:0]  dec_rd;
  logic        dec_load;
  logic [31:0] dec_imm;

  always_comb begin
    dec_rd   = 5'd0;
    dec_load = 1'b0;
    case (op)
      6'h00: dec_rd = rd_f;
      6'h23: begin
        dec_rd   = rt_f;
        dec_load = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: dec_rd = rt_f;
      6'h03: dec_rd = 5'd31;
      default: dec_rd = 5'd0;
    endcase
  end

  always_comb begin
    dec_imm = {{16{imm16[15]}}, imm16};
    case (op)
      6'h0c, 6'h0d, 6'h0e: dec_imm = {16'd0, imm16};
      6'h0f:               dec_imm = {imm16, 16'd0};
      default:             dec_imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Later assignments override earlier ones, so the order below is lowest priority first.
  logic [31:0] v1_rd;
  logic [31:0] v2_rd;

  always_comb begin
    v1_rd = regs_q[rs_f];
    if (WB_BYPASS && d.W_en && (d.W_rd == rs_f)) v1_rd = d.W_data;
    if (rs_f == 5'd0) v1_rd = '0;
    if (d.v1_mux) v1_rd = d.v1_fw;

    v2_rd = regs_q[rt_f];
    if (WB_BYPASS && d.W_en && (d.W_rd == rt_f)) v2_rd = d.W_data;
    if (rt_f == 5'd0) v2_rd = '0;
    if (d.v2_mux) v2_rd = d.v2_fw;
  end

  logic        e_valid_q, e_valid_d;
  logic [31:0] e_pc_q, e_pc_d;
  logic [5:0]  e_op_q, e_op_d;
  logic [5:0]  e_funct_q, e_funct_d;
  logic [31:0] e_v1_q, e_v1_d;
  logic [31:0] e_v2_q, e_v2_d;
  logic [31:0] e_imm_q, e_imm_d;
  logic [4:0]  e_rd_q, e_rd_d;
  logic        e_is_load_q, e_is_load_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    e_valid_d      = 1'b0;
    e_pc_d         = '0;
    e_op_d         = '0;
    e_funct_d      = '0;
    e_v1_d         = '0;
    e_v2_d         = '0;
    e_imm_d        = '0;
    e_rd_d         = '0;
    e_is_load_d    = 1'b0;
    bubble_count_d = bubble_count_q;
    if (d.flush || d.stall) begin
      // Only hazard-driven bubbles count; an empty IF/ID is not a stall.
      if (bubble_count_q != 32'hFFFF_FFFF) bubble_count_d = bubble_count_q + 32'd1;
    end else if (d.D_valid) begin
      e_valid_d   = 1'b1;
      e_pc_d      = d.D_pc;
      e_op_d      = op;
      e_funct_d   = funct;
      e_v1_d      = v1_rd;
      e_v2_d      = v2_rd;
      e_imm_d     = dec_imm;
      e_rd_d      = dec_rd;
      e_is_load_d = dec_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q      <= 1'b0;
      e_pc_q         <= '0;
      e_op_q         <= '0;
      e_funct_q      <= '0;
      e_v1_q         <= '0;
      e_v2_q         <= '0;
      e_imm_q        <= '0;
      e_rd_q         <= '0;
      e_is_load_q    <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      e_valid_q      <= e_valid_d;
      e_pc_q         <= e_pc_d;
      e_op_q         <= e_op_d;
      e_funct_q      <= e_funct_d;
      e_v1_q         <= e_v1_d;
      e_v2_q         <= e_v2_d;
      e_imm_q        <= e_imm_d;
      e_rd_q         <= e_rd_d;
      e_is_load_q    <= e_is_load_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign d.E_valid      = e_valid_q;
  assign d.E_pc         = e_pc_q;
  assign d.E_op         = e_op_q;
  assign d.E_funct      = e_funct_q;
  assign d.E_v1         = e_v1_q;
  assign d.E_v2         = e_v2_q;
  assign d.E_imm        = e_imm_q;
  assign d.E_rd         = e_rd_q;
  assign d.E_is_load    = e_is_load_q;
  assign d.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural model; bypass and no-bypass builds run side by side.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        d_valid, stall, flush, v1_mux, v2_mux, w_en;
  logic [31:0] d_instr, d_pc, v1_fw, v2_fw, w_data;
  logic [4:0]  w_rd;

  decode_stage_if if1 ();
  decode_stage_if if0 ();

  always_comb begin
    if1.D_valid = d_valid;  if0.D_valid = d_valid;
    if1.D_instr = d_instr;  if0.D_instr = d_instr;
    if1.D_pc    = d_pc;     if0.D_pc    = d_pc;
    if1.stall   = stall;    if0.stall   = stall;
    if1.flush   = flush;    if0.flush   = flush;
    if1.v1_mux  = v1_mux;   if0.v1_mux  = v1_mux;
    if1.v2_mux  = v2_mux;   if0.v2_mux  = v2_mux;
    if1.v1_fw   = v1_fw;    if0.v1_fw   = v1_fw;
    if1.v2_fw   = v2_fw;    if0.v2_fw   = v2_fw;
    if1.W_en    = w_en;     if0.W_en    = w_en;
    if1.W_rd    = w_rd;     if0.W_rd    = w_rd;
    if1.W_data  = w_data;   if0.W_data  = w_data;
  end

  decode_stage #(.WB_BYPASS(1'b1)) dut1 (.clk(clk), .reset(rst), .d(if1.slave));
  decode_stage #(.WB_BYPASS(1'b0)) dut0 (.clk(clk), .reset(rst), .d(if0.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_bub;

  function automatic logic [31:0] m_imm(input logic [31:0] instr);
    logic [5:0] o = instr[31:26];
    logic [15:0] i16 = instr[15:0];
    if (o == 6'h0f) return {i16, 16'h0000};
    if (o inside {6'h0c, 6'h0d, 6'h0e}) return 32'(i16);
    return 32'($signed(i16));
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] instr);
    logic [5:0] o = instr[31:26];
    if (o == 6'h00) return instr[15:11];
    if (o inside {6'h23, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f}) return instr[20:16];
    if (o == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic mux,
                                         input logic [31:0] fw, input bit bypass);
    if (mux) return fw;
    if (r == 5'd0) return 32'd0;
    if (bypass && w_en && w_rd == r) return w_data;
    return m_regs[r];
  endfunction

  task automatic set_idle();
    d_valid = 0; d_instr = 0; d_pc = 0; stall = 0; flush = 0;
    v1_mux = 0; v2_mux = 0; v1_fw = 0; v2_fw = 0;
    w_en = 0; w_rd = 0; w_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_bub = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    d_instr = 32'hFFFF_FFFF;
    rst = 1;
    #1;
    n_checks++;
    if ({if1.E_valid, if1.E_pc, if1.E_v1, if1.E_v2, if1.E_imm, if1.E_rd, if1.E_is_load, if1.bubble_count} !== '0)
      $display("FAIL reset_outputs: got valid=%b pc=%h rd=%0d bub=%0d, expected all zero",
               if1.E_valid, if1.E_pc, if1.E_rd, if1.bubble_count);
    else n_pass++;
    n_checks++;
    if ({if1.rs, if1.rt} !== 10'd0)
      $display("FAIL rs_rt_invalid: got rs=%0d rt=%0d expected 0 0", if1.rs, if1.rt);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_bub = 0;
  endtask

  task automatic test_write_read();
    set_idle();
    w_en = 1; w_rd = 5; w_data = 32'h1234_5678;
    step();
    set_idle();
    d_valid = 1; d_pc = 32'h0000_0040;
    d_instr = {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
    #1;
    n_checks++;
    if (if1.rs !== 5'd5 || if1.rt !== 5'd0)
      $display("FAIL rs_rt_add: got rs=%0d rt=%0d expected 5 0", if1.rs, if1.rt);
    else n_pass++;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'h1234_5678 || if0.E_v1 !== 32'h1234_5678)
      $display("FAIL write_read_v1: got %h/%h expected 12345678", if1.E_v1, if0.E_v1);
    else n_pass++;
    n_checks++;
    if (if1.E_v2 !== 32'd0 || if1.E_rd !== 5'd3 || if1.E_valid !== 1'b1 || if1.E_pc !== 32'h40 || if1.E_funct !== 6'h20)
      $display("FAIL write_read_fields: got v2=%h rd=%0d valid=%b pc=%h funct=%h expected 0 3 1 40 20",
               if1.E_v2, if1.E_rd, if1.E_valid, if1.E_pc, if1.E_funct);
    else n_pass++;
  endtask

  task automatic test_bypass();
    set_idle();
    d_valid = 1;
    d_instr = {6'h00, 5'd7, 5'd7, 5'd2, 5'd0, 6'h25};
    w_en = 1; w_rd = 7; w_data = 32'h0000_00AA;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'hAA || if1.E_v2 !== 32'hAA)
      $display("FAIL bypass_on: got %h/%h expected 000000aa/000000aa", if1.E_v1, if1.E_v2);
    else n_pass++;
    n_checks++;
    if (if0.E_v1 !== 32'h0 || if0.E_v2 !== 32'h0)
      $display("FAIL bypass_off: got %h/%h expected 0/0", if0.E_v1, if0.E_v2);
    else n_pass++;
    w_en = 0;
    step();
    n_checks++;
    if (if0.E_v1 !== 32'hAA || if0.E_v2 !== 32'hAA)
      $display("FAIL write_visible_next: got %h/%h expected 000000aa", if0.E_v1, if0.E_v2);
    else n_pass++;
  endtask

  task automatic test_forward();
    set_idle();
    d_valid = 1;
    d_instr = {6'h00, 5'd9, 5'd9, 5'd1, 5'd0, 6'h20};
    v1_mux = 1; v1_fw = 32'h0000_DEAD;
    w_en = 1; w_rd = 9; w_data = 32'h55;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'hDEAD || if0.E_v1 !== 32'hDEAD)
      $display("FAIL forward_priority: got %h/%h expected 0000dead", if1.E_v1, if0.E_v1);
    else n_pass++;
    n_checks++;
    if (if1.E_v2 !== 32'h55 || if0.E_v2 !== 32'h0)
      $display("FAIL forward_other_operand: got %h/%h expected 00000055/00000000", if1.E_v2, if0.E_v2);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    set_idle();
    d_valid = 1;
    d_instr = {6'h00, 5'd5, 5'd7, 5'd3, 5'd0, 6'h20};
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin stall = 0; flush = 1; end
      step();
      n_checks++;
      if (if1.E_valid !== 1'b0 || if1.E_rd !== 5'd0 || if1.E_v1 !== 32'd0 || if1.E_pc !== 32'd0)
        $display("FAIL bubble_%0d: got valid=%b rd=%0d v1=%h expected 0 0 0", i, if1.E_valid, if1.E_rd, if1.E_v1);
      else n_pass++;
    end
    n_checks++;
    if (if1.bubble_count !== 32'd3)
      $display("FAIL bubble_count_3: got %0d expected 3", if1.bubble_count);
    else n_pass++;
    stall = 1; flush = 1;
    step();
    n_checks++;
    if (if1.bubble_count !== 32'd4 || if1.E_valid !== 1'b0)
      $display("FAIL flush_and_stall: got count=%0d valid=%b expected 4 0", if1.bubble_count, if1.E_valid);
    else n_pass++;
    set_idle();
    step();
    n_checks++;
    if (if1.bubble_count !== 32'd4)
      $display("FAIL idle_not_counted: got %0d expected 4", if1.bubble_count);
    else n_pass++;
    d_valid = 1;
    d_instr = {6'h23, 5'd1, 5'd4, 16'hFFFC};
    step();
    n_checks++;
    if (if1.E_is_load !== 1'b1 || if1.E_rd !== 5'd4 || if1.E_imm !== 32'hFFFF_FFFC || if1.E_op !== 6'h23)
      $display("FAIL lw_decode: got load=%b rd=%0d imm=%h op=%h expected 1 4 fffffffc 23",
               if1.E_is_load, if1.E_rd, if1.E_imm, if1.E_op);
    else n_pass++;
  endtask

  task automatic test_r0_imm();
    set_idle();
    d_valid = 1;
    d_instr = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
    w_en = 1; w_rd = 0; w_data = 32'hFF;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'd0 || if1.E_v2 !== 32'd0)
      $display("FAIL r0_same_cycle: got %h/%h expected 0/0", if1.E_v1, if1.E_v2);
    else n_pass++;
    w_en = 0;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'd0 || if0.E_v1 !== 32'd0)
      $display("FAIL r0_after_write: got %h/%h expected 0/0", if1.E_v1, if0.E_v1);
    else n_pass++;
    d_instr = {6'h0c, 5'd0, 5'd6, 16'h8000};
    step();
    n_checks++;
    if (if1.E_imm !== 32'h0000_8000 || if1.E_rd !== 5'd6)
      $display("FAIL andi_imm: got imm=%h rd=%0d expected 00008000 6", if1.E_imm, if1.E_rd);
    else n_pass++;
    d_instr = {6'h08, 5'd0, 5'd6, 16'h8000};
    step();
    n_checks++;
    if (if1.E_imm !== 32'hFFFF_8000)
      $display("FAIL addi_imm: got %h expected ffff8000", if1.E_imm);
    else n_pass++;
    d_instr = {6'h0f, 5'd0, 5'd8, 16'h1234};
    step();
    n_checks++;
    if (if1.E_imm !== 32'h1234_0000 || if1.E_rd !== 5'd8)
      $display("FAIL lui_imm: got imm=%h rd=%0d expected 12340000 8", if1.E_imm, if1.E_rd);
    else n_pass++;
    d_instr = {6'h03, 26'h000_0010};
    step();
    n_checks++;
    if (if1.E_rd !== 5'd31 || if1.E_is_load !== 1'b0)
      $display("FAIL jal_rd: got rd=%0d load=%b expected 31 0", if1.E_rd, if1.E_is_load);
    else n_pass++;
    d_instr = {6'h2b, 5'd1, 5'd9, 16'h0004};
    step();
    n_checks++;
    if (if1.E_rd !== 5'd0 || if1.E_valid !== 1'b1)
      $display("FAIL sw_rd: got rd=%0d valid=%b expected 0 1", if1.E_rd, if1.E_valid);
    else n_pass++;
  endtask

  logic [5:0] op_tab [13] = '{6'h00, 6'h00, 6'h23, 6'h08, 6'h09, 6'h0a, 6'h0c,
                              6'h0d, 6'h0e, 6'h0f, 6'h03, 6'h2b, 6'h04};

  task automatic test_random();
    logic [178:0] exp1, exp0, act1, act0;
    logic [5:0]   o;
    logic [4:0]   erd;
    logic [31:0]  ev1_1, ev2_1, ev1_0, ev2_0, eimm;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 12)];
      d_instr = {o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      d_pc    = $urandom & 32'hFFFF_FFFC;
      d_valid = ($urandom_range(0, 99) < 85);
      stall   = ($urandom_range(0, 99) < 10);
      flush   = ($urandom_range(0, 99) < 8);
      v1_mux  = ($urandom_range(0, 99) < 20);
      v2_mux  = ($urandom_range(0, 99) < 20);
      v1_fw   = $urandom;
      v2_fw   = $urandom;
      w_en    = ($urandom_range(0, 1) == 1);
      w_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w_data  = $urandom;
      #1;
      n_checks++;
      if (if1.rs !== (d_valid ? d_instr[25:21] : 5'd0) || if1.rt !== (d_valid ? d_instr[20:16] : 5'd0))
        $display("FAIL rand_rs_rt[%0d]: got %0d/%0d instr=%h valid=%b", n, if1.rs, if1.rt, d_instr, d_valid);
      else n_pass++;
      exp1 = '0; exp0 = '0;
      if (stall || flush) begin
        if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      end else if (d_valid) begin
        erd   = m_dest(d_instr);
        eimm  = m_imm(d_instr);
        ev1_1 = m_read(d_instr[25:21], v1_mux, v1_fw, 1'b1);
        ev2_1 = m_read(d_instr[20:16], v2_mux, v2_fw, 1'b1);
        ev1_0 = m_read(d_instr[25:21], v1_mux, v1_fw, 1'b0);
        ev2_0 = m_read(d_instr[20:16], v2_mux, v2_fw, 1'b0);
        exp1 = {1'b1, d_pc, d_instr[31:26], d_instr[5:0], ev1_1, ev2_1, eimm, erd,
                (d_instr[31:26] == 6'h23), 32'd0};
        exp0 = {1'b1, d_pc, d_instr[31:26], d_instr[5:0], ev1_0, ev2_0, eimm, erd,
                (d_instr[31:26] == 6'h23), 32'd0};
      end
      exp1[31:0] = m_bub;
      exp0[31:0] = m_bub;
      @(posedge clk);
      if (w_en && w_rd != 5'd0) m_regs[w_rd] = w_data;
      @(negedge clk);
      act1 = {if1.E_valid, if1.E_pc, if1.E_op, if1.E_funct, if1.E_v1, if1.E_v2, if1.E_imm,
              if1.E_rd, if1.E_is_load, if1.bubble_count};
      act0 = {if0.E_valid, if0.E_pc, if0.E_op, if0.E_funct, if0.E_v1, if0.E_v2, if0.E_imm,
              if0.E_rd, if0.E_is_load, if0.bubble_count};
      n_checks++;
      if (act1 !== exp1) $display("FAIL rand_bypass[%0d]: got %h expected %h", n, act1, exp1);
      else n_pass++;
      n_checks++;
      if (act0 !== exp0) $display("FAIL rand_nobypass[%0d]: got %h expected %h", n, act0, exp0);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [31:0] want;
    set_idle();
    stall = 1;
    force dut1.bubble_count_q = 32'hFFFF_FFFD;
    #1;
    release dut1.bubble_count_q;
    want = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      step();
      if (want != 32'hFFFF_FFFF) want = want + 1;
      n_checks++;
      if (if1.bubble_count !== want)
        $display("FAIL saturation_%0d: got %h expected %h", i, if1.bubble_count, want);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    w_en = 1; w_rd = 12; w_data = 32'hCAFE_F00D;
    step();
    set_idle();
    d_valid = 1; d_pc = 32'h100;
    d_instr = {6'h00, 5'd12, 5'd12, 5'd4, 5'd0, 6'h20};
    step();
    n_checks++;
    if (if1.E_v1 !== 32'hCAFE_F00D || if1.E_valid !== 1'b1)
      $display("FAIL pre_reset_read: got %h valid=%b expected cafef00d 1", if1.E_v1, if1.E_valid);
    else n_pass++;
    stall = 1;
    #2;
    rst = 1;
    #1;
    n_checks++;
    if ({if1.E_valid, if1.E_pc, if1.E_v1, if1.E_v2, if1.E_rd, if1.bubble_count} !== '0 ||
        {if0.E_valid, if0.E_pc, if0.E_v1, if0.E_rd, if0.bubble_count} !== '0)
      $display("FAIL async_reset: got valid=%b pc=%h v1=%h rd=%0d bub=%0d expected all zero",
               if1.E_valid, if1.E_pc, if1.E_v1, if1.E_rd, if1.bubble_count);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    stall = 0;
    step();
    n_checks++;
    if (if1.E_v1 !== 32'd0 || if0.E_v1 !== 32'd0 || if1.E_valid !== 1'b1 || if1.bubble_count !== 32'd0)
      $display("FAIL regs_cleared: got v1=%h/%h valid=%b bub=%0d expected 0 0 1 0",
               if1.E_v1, if0.E_v1, if1.E_valid, if1.bubble_count);
    else n_pass++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_forward();
    test_bubbles();
    test_r0_imm();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline: sits between the IF/ID register and the execute stage. It owns the 32×32 architectural register file, decodes the instruction held in IF/ID, and presents rs/rt to the hazard controller. It merges the controller's forwarding values into the operands and drives the ID/EX pipeline register, inserting bubbles on stall or flush.

## Interface
Parameters
- `WB_BYPASS`, default 1: when 1, a same-cycle writeback to the register being read is bypassed into the read value (write-before-read semantics).

Ports
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears register file and ID/EX register.
- `D_valid`  in  1  IF/ID holds a valid instruction.
- `D_instr`  in  32  instruction in IF/ID.
- `D_pc`  in  32  PC of `D_instr`.
- `stall`  in  1  load-use stall from hazard controller.
- `flush`  in  1  redirect from execute (taken branch/jump); kills the decoding instruction.
- `v1_mux`, `v2_mux`  in  1  select forwarded operand.
- `v1_fw`, `v2_fw`  in  32  forwarded operand values.
- `W_en`  in  1  writeback enable.
- `W_rd`  in  5  writeback destination.
- `W_data`  in  32  writeback data.
- `rs`, `rt`  out  5  `D_instr[25:21]`, `D_instr[20:16]`; combinational, forced to 0 when `D_valid`=0.
- `E_valid`  out  1  ID/EX holds a valid instruction.
- `E_pc`  out  32  PC of ID/EX instruction.
- `E_op`, `E_funct`  out  6  opcode and funct fields.
- `E_v1`, `E_v2`  out  32  resolved operands.
- `E_imm`  out  32  extended immediate.
- `E_rd`  out  5  destination register (0 = none).
- `E_is_load`  out  1  ID/EX instruction is `lw`.
- `bubble_count`  out  32  saturating count of inserted bubbles.

## Operation
- Destination decode (`op`=`D_instr[31:26]`):
  - `op`=0x00: `rd`=`D_instr[15:11]`.
  - 0x23 (lw): `rd`=rt, load=1.
  - 0x08/0x09/0x0a/0x0c/0x0d/0x0e/0x0f: `rd`=rt.
  - 0x03 (jal): `rd`=31.
  - 0x2b/0x04/0x05/0x02 and any other opcode: `rd`=0.
- Immediate: zero-extend `D_instr[15:0]` for 0x0c/0x0d/0x0e; sign-extend otherwise; 0x0f (lui) gives `{imm,16'b0}`.
- Operand read, priority high→low:
  - `vN_mux`=1 → `vN_fw`.
  - `WB_BYPASS` && `W_en` && `W_rd`==reg && reg≠0 → `W_data`.
  - `regs[reg]`.
  - Register 0 always reads 0 on the last two paths.
- Register file: on rising edge, `regs[W_rd]`←`W_data` when `W_en` && `W_rd`≠0. Writes to r0 are discarded.
- ID/EX update each rising edge, priority:
  - `flush` → bubble.
  - else `stall` → bubble.
  - else `D_valid` → capture decoded fields.
  - else bubble.
- Bubble definition: `E_valid`=0, `E_rd`=0, `E_is_load`=0; all other `E_*` fields 0.
- `bubble_count` increments on every edge that loads a bubble due to `flush` or `stall` (not for `D_valid`=0). It saturates at 0xFFFFFFFF.
- The block does not hold IF/ID; on `stall` the upstream fetch stage holds `D_instr`/`D_pc`.

## Timing
- Decode latency is one cycle: fields presented on cycle N appear on `E_*` after edge N.
- `rs`/`rt` are combinational from IF/ID, so the hazard controller resolves within the same cycle.
- Writeback visibility: a write on edge N is readable via the array from cycle N+1, and via bypass in cycle N when `WB_BYPASS`=1.
- Reset (asynchronous assert, synchronous-edge release) drives:
  - all 32 registers = 0;
  - all `E_*` = 0;
  - `bubble_count` = 0.
- Reset mid-stall or mid-flush discards the pending instruction; the first post-reset edge behaves per the priority list.
- Simultaneous `flush` and `stall`: a single bubble is loaded, and `bubble_count` increments by 1.
- Simultaneous `W_en` to r0 with a read of r0: the read returns 0.

## Test plan
- **Reset and write/read:** reset, then write r5=0x12345678. Decode `add $3,$5,$0` on the next cycle → `E_v1`=0x12345678, `E_v2`=0, `E_rd`=3, `E_valid`=1.
- **Bypass:** in one cycle, `W_en`=1 with `W_rd`=7, `W_data`=0xAA, while decoding `or $2,$7,$7` → `E_v1`=`E_v2`=0xAA. With `WB_BYPASS`=0, both read the old value 0.
- **Forwarding priority:** `v1_mux`=1 with `v1_fw`=0xDEAD and a pending writeback to rs → `E_v1`=0xDEAD.
- **Stall and flush bubbles:** `stall` for 2 cycles then `flush` for 1 cycle → 3 bubbles (`E_valid`=0, `E_rd`=0) and `bubble_count`=3. Then `lw $4,-4($1)` → `E_is_load`=1, `E_rd`=4, `E_imm`=0xFFFFFFFC.
- **Register 0 and immediates:** write r0=0xFF then read r0 → 0. `andi` with imm 0x8000 → `E_imm`=0x00008000. `lui` with 0x1234 → `E_imm`=0x12340000. `jal` → `E_rd`=31.
- **Saturation and async reset:** force `bubble_count` near 0xFFFFFFFF, keep stalling → holds 0xFFFFFFFF. Assert `reset` between edges → all outputs read 0 immediately.
